// File: rtl/cntr_seg7_pkg.sv
// Shared constants and types for the counter 7-segment display stage.
// Holds the hex glyph table and the display output polarity helper.
package cntr_seg7_pkg;

    localparam int NDIG = 4;
    localparam int KW = $clog2(NDIG);

    // Segment order is {g,f,e,d,c,b,a}; entry 0 sits in the low bits.
    localparam logic [15:0][6:0] GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [6:0]      seg;
        logic            dp;
        logic [NDIG-1:0] dig;
    } disp_t;

    localparam disp_t DISP_OFF = '0;

    function automatic disp_t polar(input disp_t d, input bit inv);
        disp_t r;
        r = inv ? ~d : d;
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Hex digit to 7-segment glyph decoder (purely combinational).
// Output is active-high; polarity is applied at the output flops.
module seg7_hex_dec
    import cntr_seg7_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = GLYPH[val];

endmodule

// File: rtl/cntr_seg7_scan.sv
// 4-digit multiplexed hex display of the last four distinct counter values.
// Each digit slot is one blank cycle followed by SCAN_DIV-1 lit cycles.
module cntr_seg7_scan
    import cntr_seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [3:0]       cnt_i,
    input  logic             en_i,
    output logic [6:0]       seg_o,
    output logic             dp_o,
    output logic [NDIG-1:0]  dig_o,
    output logic             upd_o,
    output logic [11:0]      io_oeb_o
);

    localparam logic [15:0] P_LAST = 16'(SCAN_DIV - 1);

    logic [3:0]      hist [NDIG];
    logic [NDIG-1:0] hist_v;
    logic [15:0]     p;
    logic [KW-1:0]   k;
    disp_t           disp_q;
    disp_t           disp_d;
    logic            upd_q;
    logic            shift;
    logic            lit;
    logic [3:0]      cur;
    logic [6:0]      glyph;

    assign shift = en_i && (cnt_i != hist[0]);
    assign cur   = hist[k];
    assign lit   = en_i && (p != '0) && hist_v[k];

    seg7_hex_dec u_dec (
        .val (cur),
        .seg (glyph)
    );

    always_comb begin
        disp_d = DISP_OFF;
        if (lit) begin
            disp_d.seg = glyph;
            disp_d.dp  = (k == '0);
            disp_d.dig = NDIG'(1) << k;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < NDIG; i++) begin
                hist[i] <= '0;
            end
            hist_v <= NDIG'(1);
            p      <= '0;
            k      <= '0;
            disp_q <= polar(DISP_OFF, ACTIVE_LOW);
            upd_q  <= 1'b0;
        end else begin
            upd_q  <= shift;
            disp_q <= polar(disp_d, ACTIVE_LOW);
            if (shift) begin
                for (int i = NDIG - 1; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                hist[0] <= cnt_i;
                hist_v  <= {hist_v[NDIG-2:0], 1'b1};
            end
            if (!en_i) begin
                p <= '0;
                k <= '0;
            end else if (p == P_LAST) begin
                p <= '0;
                k <= k + KW'(1);
            end else begin
                p <= p + 16'd1;
            end
        end
    end

    assign seg_o    = disp_q.seg;
    assign dp_o     = disp_q.dp;
    assign dig_o    = disp_q.dig;
    assign upd_o    = upd_q;
    assign io_oeb_o = '0;

endmodule
